cellnet_rr_merge: RTL and testbench
===================================

# cellnet_rr_merge

N-channel round-robin merge for cellnet links: NUM_CH cellnet sources, each with its own 4-phase req/ack handshake, share one downstream cellnet sink channel. It is the multi-source generalisation of the single source-to-sink test network. Addresses and data are registered, and handshake inputs pass through optional synchronisers so sources and sinks may run on divided clocks. It also provides a sticky protocol-error flag and a transaction counter.

## Interface
- NUM_CH, 4: number of upstream source channels (2..16)
- ADDR_SZ, 8: address width (set from `ADDRESS_SIZE at top level)
- DATA_SZ, 8: data width (set from `DATA_SIZE at top level)
- SYNC_STAGES, 2: flops on each i_req/i_ack bit (0 = inputs already synchronous to i_clk)
- CNT_W, 16: transaction counter width
- One clock; reset is synchronous and active-high.
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  NUM_CH  per-channel request
- o_ack  out  NUM_CH  per-channel acknowledge
- i_addr  in  NUM_CH*ADDR_SZ  flat; channel k occupies [k*ADDR_SZ +: ADDR_SZ]
- i_dat  in  NUM_CH*DATA_SZ  flat; channel k occupies [k*DATA_SZ +: DATA_SZ]
- o_req  out  1  downstream request
- i_ack  in  1  downstream acknowledge
- o_addr  out  ADDR_SZ  registered address of the granted message
- o_dat  out  DATA_SZ  registered data of the granted message
- o_ch  out  clog2(NUM_CH)  index of the granted channel
- o_busy  out  1  FSM is not in IDLE
- o_err  out  1  sticky protocol-violation flag
- o_count  out  CNT_W  number of completed transactions; wraps

## Operation
- Every output resets to 0. FSM resets to IDLE and rr_ptr resets to 0.
- Internal signals s_req and s_ack are i_req and i_ack delayed by SYNC_STAGES flops. i_addr/i_dat are not synchronised; the protocol requires them to be stable while req is high.
- IDLE: if any s_req bit is set, the winner is the first set channel scanning cyclically from rr_ptr. On that edge: capture the winner's addr/dat into o_addr/o_dat, set o_ch = winner, set o_req = 1, and go to REQ.
- REQ: wait for s_ack = 1. On that edge: o_req = 0, o_ack[o_ch] = 1, go to DONE.
- DONE: wait for both s_ack = 0 and s_req[o_ch] = 0 on the same edge. On that edge: o_ack[o_ch] = 0, o_count += 1 (wraps modulo 2^CNT_W), rr_ptr = (o_ch+1) mod NUM_CH, go to IDLE.
- At most one o_ack bit is high at any time. The granted channel is never re-granted until its req has been observed low.
- o_err is set, and is cleared only by i_rst, in three cases:
  - s_req[o_ch] falls while in REQ (source withdrew). The transaction still completes with the captured data.
  - s_ack = 1 while in IDLE.
  - s_ack = 0 is seen in REQ after a 1 was already seen (cannot happen by construction; this is an assertion only).
- Requests on other channels during REQ/DONE are held off. They are arbitrated in IDLE after completion, starting at rr_ptr.
- Reset mid-transaction: all outputs are 0 on the next edge and the synchronisers are cleared. Requests still high after reset are arbitrated afresh from channel 0.

## Timing
- Latency from i_req first sampled high to o_req high is SYNC_STAGES+1 cycles.
- Latency from i_ack first sampled high to o_ack high (and o_req low) is SYNC_STAGES+1 cycles.
- o_addr/o_dat/o_ch are stable from o_req rising until the next IDLE grant.
- Back-to-back grants: the minimum gap from o_ack falling to the next o_req rising is 1 cycle, provided another s_req is already high.
- With all channels requesting continuously, grant order is 0,1,2,…,NUM_CH-1,0…

## Structure
- Shared header hglobal.v (already included codebase-wide) holds `ON/`OFF, `ADDRESS_SIZE, `DATA_SIZE, and new `CN_ST_IDLE/`CN_ST_REQ/`CN_ST_DONE 2-bit state encodings.
- Sub-module cellnet_rr_pick: combinational. Inputs are the req vector and rr_ptr; outputs are found and index. It is instantiated once.
- The synchronisers are a generate loop inside this block; there is no separate module.

## Test plan
- Defaults, SYNC_STAGES=2. Ch2 req with addr=0x15, dat=0xA7 → o_req rises 3 cycles later, o_addr=0x15, o_dat=0xA7, o_ch=2. Downstream acks → o_ack[2]=1 3 cycles later. Both drop → o_ack[2]=0, o_count=1, o_err=0.
- All 4 channels hold req and the sink auto-acks → grants in order 0,1,2,3,0. Each o_ack is exclusive (one-hot or zero every cycle).
- Ch1 drops req while in REQ → o_err=1 and stays 1. The transaction still completes and o_count increments.
- i_ack pulsed high with no request pending → o_err=1, o_req stays 0, FSM stays IDLE.
- i_rst asserted for 1 cycle while in DONE → next cycle all outputs are 0. Ch3 still requesting is then re-granted with o_ch=3.
- CNT_W=2: 5 transactions → o_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/cellnet_rr_merge_pkg.sv
// rtl/cellnet_rr_merge_pkg.sv - shared state encodings and default widths for the cellnet merge
package cellnet_rr_merge_pkg;

    typedef logic [1:0] cn_state_t;

    localparam cn_state_t CN_ST_IDLE = 2'd0;
    localparam cn_state_t CN_ST_REQ  = 2'd1;
    localparam cn_state_t CN_ST_DONE = 2'd2;

    localparam int CN_ADDRESS_SIZE = 8;
    localparam int CN_DATA_SIZE    = 8;

endpackage

// File: rtl/cellnet_rr_merge_pick.sv
// rtl/cellnet_rr_merge_pick.sv - combinational round-robin picker: first set req at or after ptr
module cellnet_rr_pick
    import cellnet_rr_merge_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  index
);

    logic [NUM_CH-1:0] rot;
    logic [IDX_W:0]    off;
    logic [IDX_W:0]    sum;

    always_comb begin
        // Rotate so bit 0 is the channel at ptr, then take the lowest set offset.
        rot   = NUM_CH'({req, req} >> ptr);
        found = |rot;
        off   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = (IDX_W+1)'(i);
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDX_W+1)'(NUM_CH)) begin
            sum = sum - (IDX_W+1)'(NUM_CH);
        end
        index = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/cellnet_rr_merge.sv
// rtl/cellnet_rr_merge.sv - N-source round-robin merge onto one 4-phase req/ack cellnet sink
module cellnet_rr_merge
    import cellnet_rr_merge_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_SZ     = CN_ADDRESS_SIZE,
    parameter int DATA_SZ     = CN_DATA_SIZE,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CH-1:0]           i_req,
    output logic [NUM_CH-1:0]           o_ack,
    input  logic [NUM_CH*ADDR_SZ-1:0]   i_addr,
    input  logic [NUM_CH*DATA_SZ-1:0]   i_dat,
    output logic                        o_req,
    input  logic                        i_ack,
    output logic [ADDR_SZ-1:0]          o_addr,
    output logic [DATA_SZ-1:0]          o_dat,
    output logic [$clog2(NUM_CH)-1:0]   o_ch,
    output logic                        o_busy,
    output logic                        o_err,
    output logic [CNT_W-1:0]            o_count
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH:0]   raw_in;
    logic [NUM_CH:0]   sync_out;
    logic [NUM_CH-1:0] s_req;
    logic              s_ack;

    assign raw_in = {i_ack, i_req};

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_out = raw_in;
        end else begin : g_sync
            for (genvar b = 0; b <= NUM_CH; b++) begin : g_bit
                logic [SYNC_STAGES-1:0] chain_q;
                logic [SYNC_STAGES-1:0] chain_d;

                always_comb chain_d = (chain_q << 1) | SYNC_STAGES'(raw_in[b]);

                always_ff @(posedge i_clk) begin
                    if (i_rst) chain_q <= '0;
                    else       chain_q <= chain_d;
                end

                assign sync_out[b] = chain_q[SYNC_STAGES-1];
            end
        end
    endgenerate

    assign s_req = sync_out[NUM_CH-1:0];
    assign s_ack = sync_out[NUM_CH];

    cn_state_t         state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [DATA_SZ-1:0] dat_q, dat_d;
    logic              req_q, req_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;

    cellnet_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_pick (
        .req    (s_req),
        .ptr    (ptr_q),
        .found  (pick_found),
        .index  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        req_d   = req_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            CN_ST_IDLE: begin
                if (s_ack) err_d = 1'b1;
                if (pick_found) begin
                    addr_d  = i_addr[int'(pick_idx) * ADDR_SZ +: ADDR_SZ];
                    dat_d   = i_dat[int'(pick_idx) * DATA_SZ +: DATA_SZ];
                    ch_d    = pick_idx;
                    req_d   = 1'b1;
                    state_d = CN_ST_REQ;
                end
            end
            CN_ST_REQ: begin
                // A source dropping req here is a protocol error; the captured message still goes out.
                if (!s_req[ch_q]) err_d = 1'b1;
                if (s_ack) begin
                    req_d        = 1'b0;
                    ack_d        = '0;
                    ack_d[ch_q]  = 1'b1;
                    state_d      = CN_ST_DONE;
                end
            end
            CN_ST_DONE: begin
                if (!s_ack && !s_req[ch_q]) begin
                    ack_d   = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    ptr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                    state_d = CN_ST_IDLE;
                end
            end
            default: state_d = CN_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= CN_ST_IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            req_q   <= 1'b0;
            ack_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_req   = req_q;
    assign o_ack   = ack_q;
    assign o_addr  = addr_q;
    assign o_dat   = dat_q;
    assign o_ch    = ch_q;
    assign o_busy  = (state_q != CN_ST_IDLE);
    assign o_err   = err_q;
    assign o_count = cnt_q;

endmodule

// File: tb/tb_cellnet_rr_merge.sv
// tb/tb_cellnet_rr_merge.sv - self-checking bench for cellnet_rr_merge
module tb_cellnet_rr_merge;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_req;
    logic [31:0] i_addr;
    logic [31:0] i_dat;
    logic        i_ack;
    logic [3:0]  o_ack;
    logic        o_req;
    logic [7:0]  o_addr;
    logic [7:0]  o_dat;
    logic [1:0]  o_ch;
    logic        o_busy;
    logic        o_err;
    logic [15:0] o_count;
    logic [3:0]  b_ack;
    logic        b_req;
    logic [7:0]  b_addr;
    logic [7:0]  b_dat;
    logic [1:0]  b_ch;
    logic        b_busy;
    logic        b_err;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int exp_err = 0;
    int mptr = 0;

    always #5 clk = ~clk;

    cellnet_rr_merge u_dut (
        .i_clk (clk), .i_rst (i_rst), .i_req (i_req), .o_ack (o_ack),
        .i_addr (i_addr), .i_dat (i_dat), .o_req (o_req), .i_ack (i_ack),
        .o_addr (o_addr), .o_dat (o_dat), .o_ch (o_ch), .o_busy (o_busy),
        .o_err (o_err), .o_count (o_count)
    );

    cellnet_rr_merge #(.CNT_W(2)) u_dut_w2 (
        .i_clk (clk), .i_rst (i_rst), .i_req (i_req), .o_ack (b_ack),
        .i_addr (i_addr), .i_dat (i_dat), .o_req (b_req), .i_ack (i_ack),
        .o_addr (b_addr), .o_dat (b_dat), .o_ch (b_ch), .o_busy (b_busy),
        .o_err (b_err), .o_count (b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(o_ack)) begin
            errors++;
            $display("FAIL ack_onehot: got %b, expected one-hot or zero (t=%0t)", o_ack, $time);
        end
    end

    function automatic int rr_model(input logic [3:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int ch, input logic [7:0] a, input logic [7:0] d);
        i_addr[ch*8 +: 8] = a;
        i_dat[ch*8 +: 8]  = d;
        i_req[ch]         = 1'b1;
    endtask

    task automatic wait_oreq(input logic v);
        int n = 0;
        while (o_req !== v && n < 40) begin @(negedge clk); n++; end
        chk("wait_o_req", 32'(o_req), 32'(v));
    endtask

    task automatic wait_oack(input int ch, input logic v);
        int n = 0;
        while (o_ack[ch] !== v && n < 40) begin @(negedge clk); n++; end
        chk("wait_o_ack", 32'(o_ack[ch]), 32'(v));
    endtask

    task automatic do_xfer(input int ch, input logic [7:0] a, input logic [7:0] d);
        wait_oreq(1'b1);
        chk("grant_ch", 32'(o_ch), 32'(ch));
        chk("grant_addr", 32'(o_addr), 32'(a));
        chk("grant_dat", 32'(o_dat), 32'(d));
        chk("grant_busy", 32'(o_busy), 32'd1);
        i_ack = 1'b1;
        wait_oack(ch, 1'b1);
        chk("ack_req_low", 32'(o_req), 32'd0);
        i_req[ch] = 1'b0;
        i_ack     = 1'b0;
        wait_oack(ch, 1'b0);
        exp_count = (exp_count + 1) % 65536;
        chk("count", 32'(o_count), 32'(exp_count));
        chk("count_w2", 32'(b_count), 32'(exp_count % 4));
        chk("err", 32'(o_err), 32'(exp_err));
        mptr = (ch + 1) % N;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_o_req"}, 32'(o_req), 32'd0);
        chk({tag, "_o_ack"}, 32'(o_ack), 32'd0);
        chk({tag, "_o_addr"}, 32'(o_addr), 32'd0);
        chk({tag, "_o_dat"}, 32'(o_dat), 32'd0);
        chk({tag, "_o_ch"}, 32'(o_ch), 32'd0);
        chk({tag, "_o_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_o_err"}, 32'(o_err), 32'd0);
        chk({tag, "_o_count"}, 32'(o_count), 32'd0);
        chk({tag, "_count_w2"}, 32'(b_count), 32'd0);
    endtask

    typedef struct {
        int         ch;
        logic [7:0] addr;
        logic [7:0] dat;
        int         exp_ch;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] mask;
        logic [7:0] ra [4];
        logic [7:0] rd [4];
        bit         quiet;

        vecs[0] = '{0, 8'h00, 8'hFF, 0};
        vecs[1] = '{3, 8'hFF, 8'h00, 3};
        vecs[2] = '{1, 8'hA5, 8'h5A, 1};
        vecs[3] = '{1, 8'h12, 8'h34, 1};
        vecs[4] = '{2, 8'h80, 8'h01, 2};
        vecs[5] = '{0, 8'h7E, 8'hE7, 0};

        i_rst = 1'b1; i_req = '0; i_ack = 1'b0; i_addr = '0; i_dat = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        i_rst = 1'b0;
        @(negedge clk);

        // Directed single transfer on ch2 with latency checks.
        raise(2, 8'h15, 8'hA7);
        @(negedge clk); @(negedge clk);
        chk("lat_req_early", 32'(o_req), 32'd0);
        @(negedge clk);
        chk("lat_req", 32'(o_req), 32'd1);
        chk("d_addr", 32'(o_addr), 32'h15);
        chk("d_dat", 32'(o_dat), 32'hA7);
        chk("d_ch", 32'(o_ch), 32'd2);
        i_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("lat_ack_early", 32'(o_ack), 32'd0);
        @(negedge clk);
        chk("lat_ack", 32'(o_ack), 32'b0100);
        chk("lat_ack_req_low", 32'(o_req), 32'd0);
        i_req[2] = 1'b0; i_ack = 1'b0;
        wait_oack(2, 1'b0);
        exp_count = 1; mptr = 3;
        chk("d_count", 32'(o_count), 32'd1);
        chk("d_err", 32'(o_err), 32'd0);

        for (int i = 0; i < 6; i++) begin
            raise(vecs[i].ch, vecs[i].addr, vecs[i].dat);
            do_xfer(vecs[i].exp_ch, vecs[i].addr, vecs[i].dat);
        end

        // Source withdraws while the downstream request is outstanding.
        raise(1, 8'h5A, 8'h66);
        wait_oreq(1'b1);
        chk("wd_ch", 32'(o_ch), 32'd1);
        i_req[1] = 1'b0;
        repeat (4) @(negedge clk);
        exp_err = 1;
        chk("wd_err", 32'(o_err), 32'd1);
        chk("wd_req_held", 32'(o_req), 32'd1);
        do_xfer(1, 8'h5A, 8'h66);
        repeat (3) @(negedge clk);
        chk("wd_err_sticky", 32'(o_err), 32'd1);

        // Reset while in DONE; ch3 keeps requesting and is re-granted.
        raise(3, 8'h3C, 8'hC3);
        wait_oreq(1'b1);
        i_ack = 1'b1;
        wait_oack(3, 1'b1);
        i_rst = 1'b1; i_ack = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        i_rst = 1'b0;
        exp_count = 0; exp_err = 0; mptr = 0;
        do_xfer(3, 8'h3C, 8'hC3);

        // Stray downstream ack with nothing pending.
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (o_req !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
        end
        chk("stray_ack_idle", 32'(quiet), 32'd1);
        chk("stray_ack_err", 32'(o_err), 32'd1);
        exp_err = 1;

        // All four requesting from rr_ptr=0: fixed rotation.
        for (int k = 0; k < N; k++) raise(k, 8'(8'h40 + k), 8'(8'hB0 + k));
        for (int k = 0; k < N; k++) do_xfer(k, 8'(8'h40 + k), 8'(8'hB0 + k));
        raise(0, 8'h99, 8'h11);
        do_xfer(0, 8'h99, 8'h11);

        // Random request sets against the round-robin model.
        for (int r = 0; r < 25; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                ra[k] = 8'($urandom);
                rd[k] = 8'($urandom);
                if (mask[k]) raise(k, ra[k], rd[k]);
            end
            while (mask != 4'd0) begin
                int c;
                c = rr_model(mask, mptr);
                do_xfer(c, ra[c], rd[c]);
                mask[c] = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
